// File: rtl/pzcorebus_request_arbiter_pkg.sv
// Shared pzcorebus types for the request arbiter slice.
//   pzcorebus_config             : bus widths shared by every port of a bus instance
//   pzcorebus_command_type       : request command encoding
//   pzcorebus_command_with_data  : true for commands followed by a write-data burst
package pzcorebus_request_arbiter_pkg;

  typedef struct packed {
    int id_width;
    int address_width;
    int length_width;
    int param_width;
    int info_width;
    int data_width;
  } pzcorebus_config;

  localparam pzcorebus_config PZCOREBUS_DEFAULT_CONFIG = '{
    id_width:      4,
    address_width: 32,
    length_width:  4,
    param_width:   4,
    info_width:    4,
    data_width:    32
  };

  typedef enum logic [3:0] {
    PZCOREBUS_NULL_COMMAND     = 4'h0,
    PZCOREBUS_READ             = 4'h1,
    PZCOREBUS_WRITE            = 4'h2,
    PZCOREBUS_WRITE_NON_POSTED = 4'h3,
    PZCOREBUS_BROADCAST        = 4'h4,
    PZCOREBUS_ATOMIC           = 4'h5,
    PZCOREBUS_MESSAGE          = 4'h6
  } pzcorebus_command_type;

  function automatic logic pzcorebus_command_with_data(input pzcorebus_command_type cmd);
    case (cmd)
      PZCOREBUS_WRITE,
      PZCOREBUS_WRITE_NON_POSTED,
      PZCOREBUS_BROADCAST,
      PZCOREBUS_ATOMIC:  return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pzcorebus_request_arbiter_rr.sv
// Round-robin selector with a registered priority pointer.
//   i_clk, i_rst  : clock, synchronous active-high reset (pointer -> 0)
//   request       : per-port request set
//   update        : a command was accepted this cycle
//   update_index  : index of the accepted port; pointer moves just past it
//   grant         : one-hot winner, lowest index at or after the pointer
module pzcorebus_request_arbiter_rr #(
  parameter  int REQUESTS = 2,
  localparam int IW       = $clog2(REQUESTS)
)(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [REQUESTS-1:0] request,
  input  logic                update,
  input  logic [IW-1:0]       update_index,
  output logic [REQUESTS-1:0] grant
);

  logic [IW-1:0] pointer_reg;

  always_comb begin
    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < REQUESTS; i++) begin
      // wrap pointer+i without relying on a power-of-two port count
      sum = {1'b0, pointer_reg} + (IW+1)'(i);
      if (sum >= (IW+1)'(REQUESTS)) begin
        sum = sum - (IW+1)'(REQUESTS);
      end
      idx = sum[IW-1:0];
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pointer_reg <= '0;
    end else if (update) begin
      pointer_reg <= (update_index == IW'(REQUESTS - 1)) ? '0 : update_index + IW'(1);
    end
  end

endmodule

// File: rtl/pzcorebus_request_arbiter.sv
// Shares one pzcorebus request channel between REQUESTS upstream masters.
// Commands are granted round-robin; write data follows command-grant order
// through a small order FIFO of port indices.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   slave_*          : per-port upstream request channels (command + write data)
//   master_*         : shared downstream request channel
//   o_grant          : one-hot port whose command is on master_* this cycle
module pzcorebus_request_arbiter
  import pzcorebus_request_arbiter_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG      = PZCOREBUS_DEFAULT_CONFIG,
  parameter int              REQUESTS        = 2,
  parameter int              DATA_FIFO_DEPTH = 4
)(
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [REQUESTS-1:0]                  slave_mcmd_valid,
  output logic [REQUESTS-1:0]                  slave_scmd_accept,
  input  pzcorebus_command_type                slave_mcmd [REQUESTS],
  input  logic [BUS_CONFIG.id_width-1:0]       slave_mid [REQUESTS],
  input  logic [BUS_CONFIG.address_width-1:0]  slave_maddr [REQUESTS],
  input  logic [BUS_CONFIG.length_width-1:0]   slave_mlength [REQUESTS],
  input  logic [BUS_CONFIG.param_width-1:0]    slave_mparam [REQUESTS],
  input  logic [BUS_CONFIG.info_width-1:0]     slave_minfo [REQUESTS],
  input  logic [REQUESTS-1:0]                  slave_mdata_valid,
  output logic [REQUESTS-1:0]                  slave_sdata_accept,
  input  logic [BUS_CONFIG.data_width-1:0]     slave_mdata [REQUESTS],
  input  logic [BUS_CONFIG.data_width/8-1:0]   slave_mdata_byteen [REQUESTS],
  input  logic [REQUESTS-1:0]                  slave_mdata_last,
  output logic                                 master_mcmd_valid,
  input  logic                                 master_scmd_accept,
  output pzcorebus_command_type                master_mcmd,
  output logic [BUS_CONFIG.id_width-1:0]       master_mid,
  output logic [BUS_CONFIG.address_width-1:0]  master_maddr,
  output logic [BUS_CONFIG.length_width-1:0]  master_mlength,
  output logic [BUS_CONFIG.param_width-1:0]    master_mparam,
  output logic [BUS_CONFIG.info_width-1:0]     master_minfo,
  output logic                                 master_mdata_valid,
  input  logic                                 master_sdata_accept,
  output logic [BUS_CONFIG.data_width-1:0]     master_mdata,
  output logic [BUS_CONFIG.data_width/8-1:0]   master_mdata_byteen,
  output logic                                 master_mdata_last,
  output logic [REQUESTS-1:0]                  o_grant
);

  localparam int IW = $clog2(REQUESTS);
  localparam int PW = $clog2(DATA_FIFO_DEPTH);
  localparam int CW = $clog2(DATA_FIFO_DEPTH + 1);

  logic [REQUESTS-1:0] with_data;
  logic [REQUESTS-1:0] request;
  logic [REQUESTS-1:0] arb_grant;
  logic [REQUESTS-1:0] grant;
  logic [IW-1:0]       grant_index;
  logic                cmd_accept;
  logic                cmd_data_accept;
  logic                lock_valid_reg;
  logic [REQUESTS-1:0] lock_grant_reg;

  logic [IW-1:0]       fifo_mem [DATA_FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_reg;
  logic [PW-1:0]       rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic [CW-1:0]       count_next;
  logic                empty_reg;
  logic                full_reg;
  logic                bypass;
  logic                owner_valid;
  logic [IW-1:0]       owner_index;
  logic                last_accept;
  logic                push;
  logic                pop;

  // Data-carrying commands sit out while the order FIFO has no room.
  for (genvar gi = 0; gi < REQUESTS; gi++) begin : g_request
    assign with_data[gi] = pzcorebus_command_with_data(slave_mcmd[gi]);
    assign request[gi]   = slave_mcmd_valid[gi] && !(with_data[gi] && full_reg);
  end

  pzcorebus_request_arbiter_rr #(
    .REQUESTS (REQUESTS)
  ) u_rr (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .request      (request),
    .update       (cmd_accept),
    .update_index (grant_index),
    .grant        (arb_grant)
  );

  // A presented but unaccepted command keeps its grant until accepted.
  assign grant = i_rst ? '0 : (lock_valid_reg ? lock_grant_reg : arb_grant);

  always_comb begin
    grant_index = '0;
    for (int i = 0; i < REQUESTS; i++) begin
      if (grant[i]) begin
        grant_index = IW'(i);
      end
    end
  end

  assign master_mcmd_valid = |(grant & slave_mcmd_valid);
  assign master_mcmd       = slave_mcmd[grant_index];
  assign master_mid        = slave_mid[grant_index];
  assign master_maddr      = slave_maddr[grant_index];
  assign master_mlength    = slave_mlength[grant_index];
  assign master_mparam     = slave_mparam[grant_index];
  assign master_minfo      = slave_minfo[grant_index];
  assign o_grant           = grant;
  assign cmd_accept        = master_mcmd_valid && master_scmd_accept;
  assign cmd_data_accept   = cmd_accept && with_data[grant_index];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_valid_reg <= 1'b0;
      lock_grant_reg <= '0;
    end else begin
      lock_valid_reg <= master_mcmd_valid && !master_scmd_accept;
      lock_grant_reg <= grant;
    end
  end

  // Data owner: FIFO head, or the write being accepted right now when the
  // FIFO is empty so a single-beat write can finish in its command cycle.
  assign bypass      = empty_reg && cmd_data_accept;
  assign owner_valid = !i_rst && (!empty_reg || bypass);
  assign owner_index = empty_reg ? grant_index : fifo_mem[rd_ptr_reg];

  assign master_mdata_valid  = owner_valid && slave_mdata_valid[owner_index];
  assign master_mdata        = slave_mdata[owner_index];
  assign master_mdata_byteen = slave_mdata_byteen[owner_index];
  assign master_mdata_last   = slave_mdata_last[owner_index];

  for (genvar gi = 0; gi < REQUESTS; gi++) begin : g_accept
    assign slave_scmd_accept[gi]  = grant[gi] && master_scmd_accept;
    assign slave_sdata_accept[gi] = owner_valid && (owner_index == IW'(gi)) && master_sdata_accept;
  end

  assign last_accept = master_mdata_valid && master_sdata_accept && master_mdata_last;
  assign push        = cmd_data_accept && !(bypass && last_accept);
  assign pop         = last_accept && !empty_reg;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DATA_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= grant_index;
    end
  end

  // Flags are registered from the next occupancy so they leave flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == CW'(DATA_FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_pzcorebus_request_arbiter.sv
module tb_pzcorebus_request_arbiter;
  import pzcorebus_request_arbiter_pkg::*;

  localparam int R = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [R-1:0]          s_cmd_valid, s_cmd_accept, s_data_valid, s_data_accept, s_data_last;
  pzcorebus_command_type s_cmd [R];
  logic [3:0]            s_mid [R];
  logic [31:0]           s_addr [R];
  logic [3:0]            s_len [R];
  logic [3:0]            s_param [R];
  logic [3:0]            s_info [R];
  logic [31:0]           s_data [R];
  logic [3:0]            s_byteen [R];
  logic                  m_cmd_valid, m_cmd_accept, m_data_valid, m_data_accept, m_data_last;
  pzcorebus_command_type m_cmd;
  logic [3:0]            m_mid, m_len, m_param, m_info, m_byteen;
  logic [31:0]           m_addr, m_data;
  logic [R-1:0]          grant;

  pzcorebus_request_arbiter #(
    .REQUESTS        (R),
    .DATA_FIFO_DEPTH (2)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .slave_mcmd_valid    (s_cmd_valid),
    .slave_scmd_accept   (s_cmd_accept),
    .slave_mcmd          (s_cmd),
    .slave_mid           (s_mid),
    .slave_maddr         (s_addr),
    .slave_mlength       (s_len),
    .slave_mparam        (s_param),
    .slave_minfo         (s_info),
    .slave_mdata_valid   (s_data_valid),
    .slave_sdata_accept  (s_data_accept),
    .slave_mdata         (s_data),
    .slave_mdata_byteen  (s_byteen),
    .slave_mdata_last    (s_data_last),
    .master_mcmd_valid   (m_cmd_valid),
    .master_scmd_accept  (m_cmd_accept),
    .master_mcmd         (m_cmd),
    .master_mid          (m_mid),
    .master_maddr        (m_addr),
    .master_mlength      (m_len),
    .master_mparam       (m_param),
    .master_minfo        (m_info),
    .master_mdata_valid  (m_data_valid),
    .master_sdata_accept (m_data_accept),
    .master_mdata        (m_data),
    .master_mdata_byteen (m_byteen),
    .master_mdata_last   (m_data_last),
    .o_grant             (grant)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t sb[$];

  int          d_len [R];
  int          d_idx [R];
  logic [31:0] d_base [R];

  typedef struct {
    logic       rst;
    logic [1:0] vld;
    logic       acc;
    logic [1:0] exp_grant;
    logic       exp_mvalid;
    logic [1:0] exp_sacc;
    logic [3:0] exp_mid;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive_data(input int p);
    s_data[p]      = d_base[p] + 32'(d_idx[p]);
    s_data_last[p] = (d_idx[p] == d_len[p] - 1);
    s_byteen[p]    = 4'hf;
  endtask

  task automatic start_data(input int p, input int len, input logic [31:0] base);
    d_len[p]        = len;
    d_idx[p]        = 0;
    d_base[p]       = base;
    s_data_valid[p] = 1'b1;
    drive_data(p);
  endtask

  task automatic issue_write(input int p, input int len, input logic [31:0] base);
    s_cmd_valid[p] = 1'b1;
    s_cmd[p]       = PZCOREBUS_WRITE;
    s_len[p]       = 4'(len);
    s_addr[p]      = base;
    for (int k = 0; k < len; k++) begin
      sb.push_back('{data: base + 32'(k), last: (k == len - 1)});
    end
  endtask

  task automatic issue_read(input int p);
    s_cmd_valid[p] = 1'b1;
    s_cmd[p]       = PZCOREBUS_READ;
    s_addr[p]      = 32'h1000 * 32'(p + 1);
    s_len[p]       = 4'h1;
  endtask

  task automatic clear_inputs();
    s_cmd_valid  = '0;
    s_data_valid = '0;
    s_data_last  = '0;
    sb.delete();
  endtask

  // Checking point: negedge; completed data beats are scoreboarded here.
  task automatic to_check();
    beat_t b;
    @(negedge clk);
    if (m_data_valid && m_data_accept) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got data %h, required no beat", m_data);
      end else begin
        b = sb.pop_front();
        $display("beat data=%h last=%b (required %h/%b)", m_data, m_data_last, b.data, b.last);
        check("beat_data", m_data, b.data);
        check("beat_last", 32'(m_data_last), 32'(b.last));
      end
    end
  endtask

  // Advance one clock, retiring accepted commands and data beats.
  task automatic to_next();
    logic [R-1:0] ca, da;
    ca = s_cmd_accept;
    da = s_data_accept;
    @(posedge clk);
    #1;
    for (int p = 0; p < R; p++) begin
      if (s_cmd_valid[p] && ca[p]) s_cmd_valid[p] = 1'b0;
      if (s_data_valid[p] && da[p]) begin
        d_idx[p]++;
        if (d_idx[p] == d_len[p]) begin
          s_data_valid[p] = 1'b0;
          s_data_last[p]  = 1'b0;
        end else begin
          drive_data(p);
        end
      end
    end
  endtask

  task automatic tick();
    to_check();
    to_next();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    m_cmd_accept  = 1'b1;
    m_data_accept = 1'b1;
    clear_inputs();
    for (int p = 0; p < R; p++) begin
      s_cmd[p] = PZCOREBUS_READ; s_addr[p] = '0; s_len[p] = '0; s_param[p] = 4'(p);
      s_info[p] = '0; s_data[p] = '0; s_byteen[p] = '0; d_len[p] = 0; d_idx[p] = 0; d_base[p] = '0;
    end
    s_mid[0] = 4'h3;
    s_mid[1] = 4'hC;

    // Command arbitration vectors (reads only): alternation, lone requesters, lock.
    vecs[0]  = '{1'b1, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 4'h0};
    vecs[1]  = '{1'b0, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 4'h3};
    vecs[2]  = '{1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10, 4'hC};
    vecs[3]  = '{1'b0, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 4'h3};
    vecs[4]  = '{1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10, 4'hC};
    vecs[5]  = '{1'b0, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 4'hC};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 2'b01, 1'b1, 2'b01, 4'h3};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 4'h0};
    vecs[8]  = '{1'b0, 2'b11, 1'b0, 2'b10, 1'b1, 2'b00, 4'hC};
    vecs[9]  = '{1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10, 4'hC};
    vecs[10] = '{1'b0, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 4'h3};

    for (int v = 0; v < 11; v++) begin
      rst          = vecs[v].rst;
      s_cmd[0]     = PZCOREBUS_READ;
      s_cmd[1]     = PZCOREBUS_READ;
      s_cmd_valid  = vecs[v].vld;
      m_cmd_accept = vecs[v].acc;
      to_check();
      $display("vec %0d: grant=%b scmd_accept=%b mcmd_valid=%b mid=%h", v, grant, s_cmd_accept, m_cmd_valid, m_mid);
      check("vec_grant", 32'(grant), 32'(vecs[v].exp_grant));
      check("vec_mcmd_valid", 32'(m_cmd_valid), 32'(vecs[v].exp_mvalid));
      check("vec_scmd_accept", 32'(s_cmd_accept), 32'(vecs[v].exp_sacc));
      if (vecs[v].exp_grant != 2'b00) check("vec_mid", 32'(m_mid), 32'(vecs[v].exp_mid));
      to_next();
    end
    m_cmd_accept = 1'b1;

    // Write data follows command order: 4 beats from port 0, then 2 from port 1.
    do_reset();
    issue_write(0, 4, 32'hA0);
    start_data(0, 4, 32'hA0);
    start_data(1, 2, 32'hB0);
    to_check();
    check("w0_cmd_accept", 32'(s_cmd_accept), 32'h1);
    to_next();
    issue_write(1, 2, 32'hB0);
    to_check();
    check("w1_cmd_accept", 32'(s_cmd_accept), 32'h2);
    to_next();
    repeat (4) tick();
    check("order_drain", 32'(sb.size()), 32'h0);

    // Single-beat writes with data alongside the command finish in one cycle.
    issue_write(0, 1, 32'hC0);
    start_data(0, 1, 32'hC0);
    to_check();
    check("bypass0_cmd", 32'(s_cmd_accept), 32'h1);
    check("bypass0_data", 32'(s_data_accept), 32'h1);
    to_next();
    issue_write(1, 1, 32'hC8);
    start_data(1, 1, 32'hC8);
    to_check();
    check("bypass1_cmd", 32'(s_cmd_accept), 32'h2);
    check("bypass1_data", 32'(s_data_accept), 32'h2);
    to_next();
    check("bypass_drain", 32'(sb.size()), 32'h0);

    // Full order FIFO stalls a third write but lets a read through.
    do_reset();
    issue_write(0, 2, 32'hD0);
    issue_write(1, 1, 32'hE0);
    to_check();
    check("full_w0", 32'(s_cmd_accept), 32'h1);
    to_next();
    to_check();
    check("full_w1", 32'(s_cmd_accept), 32'h2);
    to_next();
    issue_write(0, 1, 32'hF0);
    issue_read(1);
    to_check();
    check("full_read_passes", 32'(s_cmd_accept), 32'h2);
    check("full_read_grant", 32'(grant), 32'h2);
    to_next();
    to_check();
    check("full_write_stalled", 32'(m_cmd_valid), 32'h0);
    to_next();
    start_data(0, 2, 32'hD0);
    tick();
    to_check();
    check("full_still_stalled", 32'(s_cmd_accept), 32'h0);
    check("full_last_beat", 32'(s_data_accept), 32'h1);
    to_next();
    to_check();
    check("full_w2_granted", 32'(s_cmd_accept), 32'h1);
    to_next();
    start_data(1, 1, 32'hE0);
    tick();
    start_data(0, 1, 32'hF0);
    tick();
    check("full_drain", 32'(sb.size()), 32'h0);

    // Presented command keeps its grant and fields while accept is low.
    do_reset();
    issue_read(0);
    tick();
    issue_read(0);
    s_addr[0]    = 32'h5A5A_0000;
    m_cmd_accept = 1'b0;
    for (int c = 0; c < 3; c++) begin
      to_check();
      check("lock_grant", 32'(grant), 32'h1);
      check("lock_addr", m_addr, 32'h5A5A_0000);
      check("lock_no_accept", 32'(s_cmd_accept), 32'h0);
      to_next();
      issue_read(1);
    end
    m_cmd_accept = 1'b1;
    to_check();
    check("lock_release", 32'(s_cmd_accept), 32'h1);
    to_next();
    to_check();
    check("lock_next", 32'(s_cmd_accept), 32'h2);
    to_next();

    // Reset in the middle of a 4-beat burst.
    do_reset();
    issue_write(0, 4, 32'h90);
    start_data(0, 4, 32'h90);
    tick();
    tick();
    rst = 1'b1;
    issue_read(1);
    for (int c = 0; c < 2; c++) begin
      to_check();
      check("rst_mcmd_valid", 32'(m_cmd_valid), 32'h0);
      check("rst_mdata_valid", 32'(m_data_valid), 32'h0);
      check("rst_scmd_accept", 32'(s_cmd_accept), 32'h0);
      check("rst_sdata_accept", 32'(s_data_accept), 32'h0);
      check("rst_grant", 32'(grant), 32'h0);
      to_next();
    end
    rst = 1'b0;
    clear_inputs();
    issue_read(0);
    issue_read(1);
    to_check();
    check("post_rst_pointer", 32'(s_cmd_accept), 32'h1);
    to_next();
    to_check();
    check("post_rst_second", 32'(s_cmd_accept), 32'h2);
    to_next();
    issue_write(1, 1, 32'h88);
    start_data(1, 1, 32'h88);
    to_check();
    check("post_rst_fifo_empty", 32'(s_data_accept), 32'h2);
    to_next();
    check("post_rst_drain", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
